// File: rtl/md_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// Optional macro MD_CANCEL_EN adds a cancel input that aborts an in-flight mul/div.
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
`ifdef MD_CANCEL_EN
    input  logic             cancel,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;
    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] f_cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] f_cond_neg_wide(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic [5:0]           r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_b;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_dz;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;

    logic                 w_cancel;
    logic                 w_idle;
    logic                 w_start_md;
    logic                 w_mthi;
    logic                 w_mtlo;
    logic                 w_s1;
    logic                 w_s2;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_mul_nxt;
    logic [WIDTH:0]       w_shift;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_sub;
    logic [WIDTH-1:0]     w_rem_nxt;
    logic [2*WIDTH-1:0]   w_div_nxt;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    assign w_idle = (r_state == S_IDLE);

`ifdef MD_CANCEL_EN
    assign w_cancel = cancel && !w_idle;
`else
    assign w_cancel = 1'b0;
`endif

    assign w_start_md = w_idle && start && !op[2];
    assign w_mthi     = w_idle && start && (op == OP_MTHI);
    assign w_mtlo     = w_idle && start && (op == OP_MTLO);

    // op[0]=0 selects the signed variants (MULT, DIV)
    assign w_s1 = !op[0] && num1[WIDTH-1];
    assign w_s2 = !op[0] && num2[WIDTH-1];

    // Multiply step: add multiplicand on LSB of multiplier, shift the 64-bit accumulator right
    always_comb begin
        w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
        w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};
    end

    // Restoring divide step: remainder in the upper half, dividend/quotient in the lower half
    always_comb begin
        w_shift   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_ge      = (w_shift >= {1'b0, r_b});
        w_sub     = w_shift[WIDTH-1:0] - r_b;
        w_rem_nxt = w_ge ? w_sub : w_shift[WIDTH-1:0];
        w_div_nxt = {w_rem_nxt, r_acc[WIDTH-2:0], w_ge};
    end

    always_comb begin
        w_prod_fix = f_cond_neg_wide(r_acc, r_neg_q);
        w_quo_fix  = f_cond_neg(r_acc[WIDTH-1:0], r_neg_q);
        w_rem_fix  = f_cond_neg(r_acc[2*WIDTH-1:WIDTH], r_neg_r);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_md) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == LAST_STEP) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_cancel) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIX) && !w_cancel;
            if (w_mthi) r_hi <= num1;
            if (w_mtlo) r_lo <= num1;
            if (w_start_md) begin
                r_cnt    <= '0;
                r_is_div <= op[1];
                r_neg_q  <= w_s1 ^ w_s2;
                r_neg_r  <= w_s1;
                r_dz     <= op[1] && (num2 == '0);
                if (op[1]) begin
                    r_acc <= {{WIDTH{1'b0}}, f_cond_neg(num1, w_s1)};
                    r_b   <= f_cond_neg(num2, w_s2);
                end else begin
                    r_acc <= {{WIDTH{1'b0}}, f_cond_neg(num2, w_s2)};
                    r_b   <= f_cond_neg(num1, w_s1);
                end
            end
            if (r_state == S_RUN) begin
                r_cnt <= r_cnt + 6'd1;
                r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
            end
            if ((r_state == S_FIX) && !w_cancel) begin
                if (r_is_div) begin
                    r_hi <= w_rem_fix;
                    r_lo <= r_dz ? {WIDTH{1'b1}} : w_quo_fix;
                end else begin
                    r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod_fix[WIDTH-1:0];
                end
            end
        end
    end

    assign busy = !w_idle;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
